// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU in the EX stage.
// Produces one quotient bit per cycle and pulses div_ready once {HI, LO} is valid.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    input  logic                 annul,
    output logic                 div_ready,
    output logic [2*WIDTH-1:0]   result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic             ready_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] diff;
    logic             q_bit;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // dvd holds the remaining dividend bits in its top end and collects
    // quotient bits at the bottom, so after WIDTH shifts it is the quotient.
    always_comb begin
        rem_shift = (rem << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};
        diff      = {1'b0, rem_shift} - {2'b00, dvs};
        q_bit     = ~diff[WIDTH+1];
        rem_next  = q_bit ? diff[WIDTH:0] : rem_shift;
        quo_next  = {dvd[WIDTH-2:0], q_bit};
        quo_fix   = neg_q ? -quo_next : quo_next;
        rem_fix   = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
        abs_a     = (signed_div && opa[WIDTH-1]) ? -opa : opa;
        abs_b     = (signed_div && opb[WIDTH-1]) ? -opb : opb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            rem     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            ready_q <= 1'b0;
            result  <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !annul) begin
                        state <= BUSY;
                        count <= '0;
                        rem   <= '0;
                        dvd   <= abs_a;
                        dvs   <= abs_b;
                        neg_q <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        neg_r <= signed_div & opa[WIDTH-1];
                    end
                end
                BUSY: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        rem   <= rem_next;
                        dvd   <= quo_next;
                        count <= count + 1'b1;
                        // Final bit: publish the corrected result as DONE begins.
                        if (count == LAST) begin
                            state   <= DONE;
                            ready_q <= 1'b1;
                            result  <= {rem_fix, quo_fix};
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A flush arriving in the DONE cycle suppresses the pulse immediately.
    assign div_ready = ready_q & ~annul;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed cases from the test plan plus random
// operands, checked against an arithmetic reference model with timing.
module tb_div_iter;
    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        div_ready;
    logic [63:0] result;

    logic [63:0] exp_q[$];
    int          exp_t_q[$];
    logic [63:0] last_exp;
    int          cyc;
    int          checks;
    int          errors;

    div_iter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .annul      (annul),
        .div_ready  (div_ready),
        .result     (result)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: truncating division, divide-by-zero gives all-ones
    // magnitude quotient and |opa| remainder before sign correction
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] q32, r32;
        if (b == 32'd0) begin
            q32 = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r32 = a;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = {32'd0, a};
                sb = {32'd0, b};
            end
            q   = sa / sb;
            r   = sa % sb;
            q32 = q[31:0];
            r32 = r[31:0];
        end
        return {r32, q32};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // drive a request at a negedge; returns the acceptance cycle
    task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output int t);
        start      = 1'b1;
        signed_div = sgn;
        opa        = a;
        opb        = b;
        t          = cyc;
        exp_q.push_back(ref_div(sgn, a, b));
        exp_t_q.push_back(t + 33);
    endtask

    task automatic run_one(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int t;
        issue(sgn, a, b, t);
        @(negedge clk);
        start = 1'b0;
        opa   = $urandom;
        opb   = $urandom;
        wait_until(t + 35);
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // monitor: every pulse must match the head of the scoreboard in value and cycle
    initial begin
        logic [63:0] e;
        int          et;
        forever begin
            @(negedge clk);
            if (div_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: pulse at cycle %0d with nothing outstanding", cyc);
                end else begin
                    e  = exp_q.pop_front();
                    et = exp_t_q.pop_front();
                    check("result", result, e);
                    check("ready_cycle", 64'(cyc), 64'(et));
                    last_exp = e;
                end
            end
        end
    end

    initial begin
        int t;
        checks     = 0;
        errors     = 0;
        last_exp   = '0;
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        opa        = '0;
        opb        = '0;
        annul      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_result", result, 64'd0);
        check("reset_ready", 64'(div_ready), 64'd0);

        // directed cases
        run_one(1'b0, 32'd100, 32'd7);
        run_one(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_one(1'b1, 32'd7, 32'hFFFF_FFFE);
        run_one(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_one(1'b0, 32'd5, 32'd0);

        // annul mid-BUSY, then a fresh division two cycles later
        issue(1'b0, 32'd100, 32'd7, t);
        @(negedge clk);
        start = 1'b0;
        wait_until(t + 10);
        annul = 1'b1;
        void'(exp_q.pop_back());
        void'(exp_t_q.pop_back());
        @(negedge clk);
        annul = 1'b0;
        check("annul_keeps_result", result, last_exp);
        begin
            int t2;
            wait_until(t + 12);
            issue(1'b0, 32'd9, 32'd3, t2);
            @(negedge clk);
            start = 1'b0;
            wait_until(t2 + 35);
        end

        // back-to-back with start held through DONE
        issue(1'b1, 32'd12, 32'd5, t);
        wait_until(t + 34);
        begin
            int t2;
            issue(1'b1, 32'd40, 32'd6, t2);
        end
        wait_until(t + 68);
        start = 1'b0;
        wait_until(t + 70);

        // synchronous reset in the middle of a division
        issue(1'b0, 32'd1000, 32'd3, t);
        @(negedge clk);
        start = 1'b0;
        wait_until(t + 20);
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(exp_t_q.pop_back());
        @(negedge clk);
        rst      = 1'b0;
        last_exp = '0;
        check("midrst_result", result, 64'd0);
        check("midrst_ready", 64'(div_ready), 64'd0);
        wait_until(t + 45);

        // randomized operands and gaps
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), pick_op(), pick_op(), t);
            @(negedge clk);
            start = 1'b0;
            opa   = $urandom;
            opb   = $urandom;
            wait_until(t + 34 + int'($urandom_range(0, 3)));
        end

        // bounded drain
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit signed/unsigned divider for the EX stage of the five-stage MIPS pipeline. It answers the hazard unit's divide stall: the hazard unit holds the EX stage while a DIV/DIVU is in EX and `div_ready` is low. This block raises `div_ready` once the quotient and remainder are valid. An exception flush cancels any division in flight.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported; the iteration count equals `WIDTH`.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a division. The EX stage holds it high while DIV/DIVU sits in EX.
- `signed_div`  in  1: 1 = DIV (signed), 0 = DIVU. Sampled with `start`.
- `opa`  in  32: dividend (rs). Sampled with `start`.
- `opb`  in  32: divisor (rt). Sampled with `start`.
- `annul`  in  1: cancel the current division. Driven from the exception flush.
- `div_ready`  out  1: result valid, one-cycle pulse. Feeds the hazard unit.
- `result`  out  64: {HI = remainder, LO = quotient}.

## Operation
- States are IDLE, BUSY and DONE.
- IDLE:
  - `start`=1 and `annul`=0 → latch operands, go to BUSY, iteration counter = 0.
  - Otherwise stay in IDLE.
- Operand latch:
  - Signed mode stores the absolute values of opa and opb.
  - It also records `neg_q = opa[31]^opb[31]` and `neg_r = opa[31]`.
  - Unsigned mode stores the raw operands and clears both sign flags.
- BUSY runs restoring radix-2 division, one quotient bit per cycle, MSB first.
  - Partial remainder is 33 bits: shift left by 1 and bring in the next dividend bit.
  - Trial-subtract the divisor.
  - If the difference is non-negative, keep it and set the quotient bit to 1; otherwise keep the old remainder and set the bit to 0.
  - After 32 iterations go to DONE.
- DONE:
  - `div_ready`=1 for exactly this cycle.
  - `result` = sign-corrected {remainder, quotient}: quotient negated if `neg_q`, remainder negated if `neg_r`.
  - Next state is IDLE unconditionally.
- `result` is registered. It holds its value from DONE until the next DONE; it is not cleared by IDLE.
- Divide by zero needs no special path: the restoring algorithm yields quotient 0xFFFFFFFF and remainder |opa|, then sign correction is applied. It takes the same latency as any other division.
- Signed overflow (0x80000000 / −1) gives LO=0x80000000, HI=0, from the natural magnitude arithmetic.
- `annul`:
  - In BUSY or DONE, the next state is IDLE.
  - `div_ready` is forced to 0 in the same cycle.
  - `result` is not updated.
  - `annul` has priority over `start`.
- `start` is ignored in BUSY. Operands are already latched, so later changes on `opa`/`opb` have no effect.

## Timing
- Reset values: state=IDLE, `div_ready`=0, `result`=0, counter=0, sign flags=0.
- Start is accepted in cycle T (IDLE, `start`=1).
  - BUSY covers cycles T+1 … T+32.
  - DONE, with `div_ready`=1, is cycle T+33.
  - Total latency is 33 cycles from acceptance to ready.
- The hazard unit drops its EX stall combinationally in T+33, so the instruction leaves EX at the T+33→T+34 edge.
- Back-to-back: `start` high in T+34 (the next DIV now in EX) is accepted. The block is in IDLE at T+34, so there is no dead cycle beyond DONE.
- `start` still high during DONE does not restart the divider. The next acceptance is possible only from IDLE.
- `rst` asserted mid-BUSY: the next cycle is IDLE with all registers at their reset values.
- `annul` in cycle X while BUSY: state is IDLE at X+1, and no `div_ready` pulse occurs for that operation.

## Test plan
- Unsigned: DIVU with opa=100, opb=7, `start` accepted at T → `div_ready` at T+33 only, `result` = {HI=0x00000002, LO=0x0000000E}.
- Signed: DIV with opa=0xFFFFFFF9 (−7), opb=2 → HI=0xFFFFFFFF (−1), LO=0xFFFFFFFD (−3). Repeat with opa=7, opb=0xFFFFFFFE → HI=1, LO=0xFFFFFFFD.
- Edge values:
  - DIV 0x80000000 / 0xFFFFFFFF → HI=0, LO=0x80000000.
  - DIVU 5 / 0 → HI=5, LO=0xFFFFFFFF, `div_ready` at T+33.
- Annul: DIVU 100/7 accepted at T, `annul` pulsed at T+10 → no `div_ready` through T+40, `result` keeps its prior value.
  - A new `start` at T+12 (DIVU 9/3) → `div_ready` at T+45, {HI=0, LO=3}.
- Back-to-back and reset:
  - Two DIVs with `start` held continuously (12/5 then 40/6) → pulses at T+33 and T+67 with {2,2} then {4,6}.
  - `rst` at T+20 of a third division → IDLE next cycle, `result`=0, `div_ready`=0.
